// File: rtl/mem_arb_2r1w_pkg.sv
// Shared types for the two-requester single-port memory arbiter.
package mem_arb_2r1w_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_e;

  localparam logic MemReqRead  = 1'b0;
  localparam logic MemReqWrite = 1'b1;

endpackage

// File: rtl/mem_arb_2r1w_arb.sv
// Combinational 2-way grant: fixed priority (req1 wins) or round-robin on last_grant.
module mem_arb_2r1w_arb #(
  parameter bit p_rr = 1'b1
) (
  input  logic val0_i,
  input  logic val1_i,
  input  logic last_grant_i,
  output logic grant_o
);

  always_comb begin
    grant_o = val1_i;
    // Under contention, round-robin hands the grant to whoever did not win last time.
    if (p_rr && val0_i && val1_i) begin
      grant_o = ~last_grant_i;
    end
  end

endmodule

// File: rtl/mem_arb_2r1w.sv
// Shares one single-ported memory between fetch (req0) and data (req1) ports, one
// transaction in flight, with a response watchdog and sticky error flag.
module mem_arb_2r1w
  import mem_arb_2r1w_pkg::*;
#(
  parameter int unsigned p_addr_nbits = 32,
  parameter int unsigned p_data_nbits = 32,
  parameter bit          p_rr         = 1'b1,
  parameter int unsigned p_timeout    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic                    req0_type,
  input  logic [p_addr_nbits-1:0] req0_addr,
  input  logic [p_data_nbits-1:0] req0_wdata,
  output logic                    resp0_val,
  output logic [p_data_nbits-1:0] resp0_data,
  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic                    req1_type,
  input  logic [p_addr_nbits-1:0] req1_addr,
  input  logic [p_data_nbits-1:0] req1_wdata,
  output logic                    resp1_val,
  output logic [p_data_nbits-1:0] resp1_data,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  output logic                    memreq_type,
  output logic [p_addr_nbits-1:0] memreq_addr,
  output logic [p_data_nbits-1:0] memreq_wdata,
  input  logic                    memresp_val,
  input  logic [p_data_nbits-1:0] memresp_data,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned       CntW   = $clog2(p_timeout);
  localparam logic [CntW-1:0]   CntMax = CntW'(p_timeout - 1);

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic grant;
  logic any_val;
  logic fire;

  mem_arb_2r1w_arb #(
    .p_rr(p_rr)
  ) u_arb (
    .val0_i      (req0_val),
    .val1_i      (req1_val),
    .last_grant_i(last_grant_q),
    .grant_o     (grant)
  );

  assign any_val = req0_val | req1_val;
  assign fire    = memreq_val & memreq_rdy;
  assign busy    = (state_q == StWait);
  assign err     = err_q;

  // Outputs are also gated by rst so nothing handshakes while reset is held.
  always_comb begin
    memreq_val   = 1'b0;
    memreq_type  = MemReqRead;
    memreq_addr  = '0;
    memreq_wdata = '0;
    req0_rdy     = 1'b0;
    req1_rdy     = 1'b0;
    resp0_val    = 1'b0;
    resp1_val    = 1'b0;
    resp0_data   = '0;
    resp1_data   = '0;
    if (rst && state_q == StIdle && any_val) begin
      memreq_val   = 1'b1;
      memreq_type  = grant ? req1_type  : req0_type;
      memreq_addr  = grant ? req1_addr  : req0_addr;
      memreq_wdata = grant ? req1_wdata : req0_wdata;
      req0_rdy     = memreq_rdy & req0_val & ~grant;
      req1_rdy     = memreq_rdy & req1_val & grant;
    end
    if (rst && state_q == StWait && memresp_val) begin
      if (owner_q) begin
        resp1_val  = 1'b1;
        resp1_data = memresp_data;
      end else begin
        resp0_val  = 1'b1;
        resp0_data = memresp_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        if (fire) begin
          state_d      = StWait;
          owner_d      = grant;
          last_grant_d = grant;
          cnt_d        = '0;
        end
      end
      StWait: begin
        // A response on the timeout cycle still wins over the watchdog.
        if (memresp_val) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arb_2r1w.sv
// Bench for mem_arb_2r1w: IDLE-grant vector table, scoreboarded transactions and
// hand-written timeout / reset sequences. A fixed-priority twin shares all inputs.
module tb_mem_arb_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_val, req0_type, req1_val, req1_type;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        memreq_rdy, memresp_val;
  logic [31:0] memresp_data;

  logic        req0_rdy, req1_rdy, resp0_val, resp1_val, memreq_val, memreq_type, busy, err;
  logic [31:0] resp0_data, resp1_data, memreq_addr, memreq_wdata;

  logic        fp_req0_rdy, fp_req1_rdy, fp_resp0_val, fp_resp1_val, fp_memreq_val;
  logic        fp_memreq_type, fp_busy, fp_err;
  logic [31:0] fp_resp0_data, fp_resp1_data, fp_memreq_addr, fp_memreq_wdata;

  always #5 clk = ~clk;

  mem_arb_2r1w #(.p_addr_nbits(32), .p_data_nbits(32), .p_rr(1'b1), .p_timeout(16)) dut (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_type(req0_type), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .resp0_val(resp0_val), .resp0_data(resp0_data),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_type(req1_type), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .resp1_val(resp1_val), .resp1_data(resp1_data),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
    .memresp_val(memresp_val), .memresp_data(memresp_data), .busy(busy), .err(err)
  );

  mem_arb_2r1w #(.p_addr_nbits(32), .p_data_nbits(32), .p_rr(1'b0), .p_timeout(16)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(fp_req0_rdy), .req0_type(req0_type), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .resp0_val(fp_resp0_val), .resp0_data(fp_resp0_data),
    .req1_val(req1_val), .req1_rdy(fp_req1_rdy), .req1_type(req1_type), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .resp1_val(fp_resp1_val), .resp1_data(fp_resp1_data),
    .memreq_val(fp_memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(fp_memreq_type),
    .memreq_addr(fp_memreq_addr), .memreq_wdata(fp_memreq_wdata),
    .memresp_val(memresp_val), .memresp_data(memresp_data), .busy(fp_busy), .err(fp_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        v0, v1, mrdy;
    logic        r0rdy, r1rdy, mval, mtype;
    logic [31:0] maddr, mwdata, fp_maddr;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts right after an edge with the request(s) already driven and memreq_rdy high.
  task automatic run_txn(input logic owner, input int lat, input logic [31:0] rdata,
                         input bit chk_fp);
    sb_t e;
    #1;
    chk("fire_val", memreq_val, 1'b1);
    chk("fire_rdy0", req0_rdy, !owner);
    chk("fire_rdy1", req1_rdy, owner);
    chk("fire_addr", memreq_addr, owner ? 32'h200 : 32'h100);
    if (chk_fp) begin
      chk("fp_rdy1", fp_req1_rdy, 1'b1);
      chk("fp_addr", fp_memreq_addr, 32'h200);
    end
    sb_q.push_back('{owner: owner, data: rdata});
    tick();
    for (int i = 0; i < lat - 1; i++) begin
      #1;
      chk("wait_busy", busy, 1'b1);
      chk("wait_noresp", {resp0_val, resp1_val, memreq_val}, 3'b000);
      tick();
    end
    memresp_val  = 1'b1;
    memresp_data = rdata;
    #1;
    chk("resp_busy", busy, 1'b1);
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("resp_val_own", e.owner ? resp1_val : resp0_val, 1'b1);
      chk("resp_val_other", e.owner ? resp0_val : resp1_val, 1'b0);
      chk("resp_data", e.owner ? resp1_data : resp0_data, e.data);
    end
    tick();
    memresp_val  = 1'b0;
    memresp_data = '0;
    #1;
    chk("post_idle", busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'hA0A0, 32'h100};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'hB1B1, 32'h200};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'hA0A0, 32'h200};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'hA0A0, 32'h200};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'hB1B1, 32'h200};

    rst = 1'b0;
    req0_val = 0; req0_type = 1'b0; req0_addr = 32'h100; req0_wdata = 32'hA0A0;
    req1_val = 0; req1_type = 1'b1; req1_addr = 32'h200; req1_wdata = 32'hB1B1;
    memreq_rdy = 1'b1; memresp_val = 1'b0; memresp_data = '0;

    // Reset state, including a request held during reset.
    tick();
    req0_val = 1'b1;
    #1;
    chk("rst_outs", {req0_rdy, req1_rdy, resp0_val, resp1_val, memreq_val, busy, err}, 7'b0);
    chk("rst_addr", memreq_addr, 32'h0);
    req0_val = 1'b0;
    tick();
    rst = 1'b1;

    // IDLE grant table (nothing fires: vals drop before each edge).
    foreach (vecs[i]) begin
      req0_val = vecs[i].v0; req1_val = vecs[i].v1; memreq_rdy = vecs[i].mrdy;
      #1;
      chk($sformatf("v%0d_rdy0", i), req0_rdy, vecs[i].r0rdy);
      chk($sformatf("v%0d_rdy1", i), req1_rdy, vecs[i].r1rdy);
      chk($sformatf("v%0d_mval", i), memreq_val, vecs[i].mval);
      chk($sformatf("v%0d_mtype", i), memreq_type, vecs[i].mtype);
      chk($sformatf("v%0d_maddr", i), memreq_addr, vecs[i].maddr);
      chk($sformatf("v%0d_mwdata", i), memreq_wdata, vecs[i].mwdata);
      chk($sformatf("v%0d_fp_maddr", i), fp_memreq_addr, vecs[i].fp_maddr);
      req0_val = 1'b0; req1_val = 1'b0;
      tick();
      chk($sformatf("v%0d_idle", i), busy, 1'b0);
    end

    // Single fetch read, response after two WAIT cycles.
    memreq_rdy = 1'b1;
    req0_val   = 1'b1;
    run_txn(1'b0, 2, 32'hDEADBEEF, 1'b0);
    req0_val = 1'b0;
    tick();

    // Memory not ready for three cycles, then fires.
    req1_val   = 1'b1;
    memreq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rdy1", req1_rdy, 1'b0);
      chk("stall_mval", memreq_val, 1'b1);
      tick();
      chk("stall_idle", busy, 1'b0);
    end
    memreq_rdy = 1'b1;
    run_txn(1'b1, 2, 32'h0BADF00D, 1'b0);

    // Both valid every cycle: round-robin alternates, fixed priority always picks req1.
    req0_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_txn(logic'(i % 2), 2, 32'h1000 + i, 1'b1);
    end
    req0_val = 1'b0; req1_val = 1'b0;
    tick();

    // Watchdog: 16 WAIT cycles with no response.
    req0_val = 1'b1;
    #1;
    chk("to_fire", req0_rdy, 1'b1);
    tick();
    req0_val = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_busy", busy, 1'b1);
      chk("to_noresp", resp0_val, 1'b0);
      tick();
    end
    #1;
    chk("to_idle", busy, 1'b0);
    chk("to_err", err, 1'b1);
    req0_val = 1'b1;
    run_txn(1'b0, 2, 32'h12345678, 1'b0);
    req0_val = 1'b0;
    chk("to_err_held", err, 1'b1);
    tick();

    // Asynchronous reset in the middle of WAIT.
    req1_val = 1'b1;
    #1;
    chk("ar_fire", req1_rdy, 1'b1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("ar_outs", {req0_rdy, req1_rdy, resp0_val, resp1_val, memreq_val, busy, err}, 7'b0);
    memresp_val  = 1'b1;
    memresp_data = 32'h55AA55AA;
    #1;
    chk("ar_drop", {resp0_val, resp1_val}, 2'b00);
    req1_val = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("ar_idle_ignore", {resp0_val, resp1_val, busy}, 3'b000);
    memresp_val = 1'b0;
    tick();

    // Response on the exact timeout cycle wins; err stays clear.
    req0_val = 1'b1;
    run_txn(1'b0, 16, 32'hCAFEF00D, 1'b0);
    req0_val = 1'b0;
    chk("edge_err", err, 1'b0);

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
